cache_fill_fsm: RTL and testbench

//  Miss-handling engine between the I/D cache arrays and the multi-cycle pipelined main memory.
//  On a cache miss it fetches one full block, one word per request.
//  It steers each returning word into the cache data array, then writes the tag.

---
 rtl/cache_pkg.sv | 13 +
 rtl/fill_counter.sv | 17 +
 rtl/cache_fill_fsm.sv | 91 +++++++++
 tb/tb_cache_fill_fsm.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache miss-handling path.
package cache_pkg;
  typedef enum logic {IDLE, FILL} fill_state_t;

  localparam int CACHE_ADDR_W   = 16;
  localparam int BLOCK_OFFSET_W = 4;
  localparam int WORD_IDX_W     = 3;

  // Clears the byte-offset bits so the address points at the first byte of its block.
  function automatic logic [CACHE_ADDR_W-1:0] block_base(input logic [CACHE_ADDR_W-1:0] addr);
    return {addr[CACHE_ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
  endfunction
endpackage

// File: rtl/fill_counter.sv
// Saturating up-counter with synchronous clear; tracks requests or returns within one fill.
module fill_counter #(
  parameter int W   = 4,
  parameter int MAX = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          cnt <= '0;
    else if (clr)                        cnt <= '0;
    else if (inc && (cnt < W'(MAX)))     cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/cache_fill_fsm.sv
// Block-fill engine: issues one read per word of the missing block, steers each
// return into the data array in arrival order, and commits the tag on the last word.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int ADDR_W          = CACHE_ADDR_W,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int WORD_BYTES      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic                  memory_data_valid,
  input  logic [15:0]           memory_data,
  output logic                  fsm_busy,
  output logic                  mem_read_en,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] word_index,
  output logic [15:0]           data_array_wdata,
  output logic                  write_tag_array
);
  localparam int CNT_W = $clog2(WORDS_PER_BLOCK) + 1;

  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  req_cnt, rcv_cnt;
  logic              start;

  assign start            = (state == IDLE) && miss_detected;
  assign data_array_wdata = memory_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      if (start) base <= block_base(miss_address);
    end
  end

  fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_req_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (mem_read_en),
    .cnt   (req_cnt)
  );

  // Returns are counted by valid pulses only, so memory latency never matters.
  fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_rcv_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .inc   (write_data_array),
    .cnt   (rcv_cnt)
  );

  always_comb begin
    state_nxt        = state;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_index       = '0;
    write_tag_array  = 1'b0;
    case (state)
      IDLE: begin
        if (miss_detected) state_nxt = FILL;
      end
      FILL: begin
        fsm_busy   = 1'b1;
        word_index = rcv_cnt[WORD_IDX_W-1:0];
        if (req_cnt < CNT_W'(WORDS_PER_BLOCK)) begin
          mem_read_en    = 1'b1;
          memory_address = base + ADDR_W'(req_cnt) * ADDR_W'(WORD_BYTES);
        end
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          if (rcv_cnt == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array = 1'b1;
            state_nxt       = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench: a per-fill return schedule predicts every request, write and tag pulse.
module tb_cache_fill_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic [15:0] memory_data = '0;
  logic        fsm_busy, mem_read_en, write_data_array, write_tag_array;
  logic [15:0] memory_address, data_array_wdata;
  logic [2:0]  word_index;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .data_array_wdata  (data_array_wdata),
    .write_tag_array   (write_tag_array)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(fsm_busy), 0);
    chk({tag, "_rd"},   32'(mem_read_en), 0);
    chk({tag, "_addr"}, 32'(memory_address), 0);
    chk({tag, "_wr"},   32'(write_data_array), 0);
    chk({tag, "_widx"}, 32'(word_index), 0);
    chk({tag, "_tag"},  32'(write_tag_array), 0);
  endtask

  // Entered and left at posedge+1; optional stale returns while idle.
  task automatic idle(input int n, input bit stale);
    for (int i = 0; i < n; i++) begin
      miss_detected     = 1'b0;
      memory_data_valid = stale;
      memory_data       = 16'($urandom);
      #1;
      chk_quiet("idle");
      @(posedge clk); #1;
    end
    memory_data_valid = 1'b0;
  endtask

  // lat_mode: 0 fixed 4, 1 cycling 4/6/9, 2 random 1..7. abort_at>0 resets after that many words.
  task automatic run_fill(input logic [15:0] addr, input int lat_mode, input bit noise, input int abort_at);
    int          sched[8];
    int          prev, lat, k, c;
    logic [15:0] base;
    base = addr & 16'hFFF0;
    prev = -1;
    for (int i = 0; i < 8; i++) begin
      case (lat_mode)
        0:       lat = 4;
        1:       lat = (i % 3 == 0) ? 4 : (i % 3 == 1) ? 6 : 9;
        default: lat = int'($urandom_range(1, 7));
      endcase
      sched[i] = (i + lat > prev + 1) ? i + lat : prev + 1;
      prev     = sched[i];
    end
    miss_detected     = 1'b1;
    miss_address      = addr;
    memory_data_valid = 1'b0;
    #1;
    chk("launch_busy", 32'(fsm_busy), 0);
    @(posedge clk); #1;
    k = 0;
    c = 0;
    while (c < 64 && k < 8) begin
      memory_data_valid = (c == sched[k]);
      memory_data       = 16'($urandom);
      miss_detected     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      miss_address      = 16'h4000;
      #1;
      chk("busy", 32'(fsm_busy), 1);
      chk("rd_en", 32'(mem_read_en), 32'(c < 8));
      if (c < 8) chk("rd_addr", 32'(memory_address), 32'(16'(base + 16'(2 * c))));
      chk("wr", 32'(write_data_array), 32'(memory_data_valid));
      chk("tag", 32'(write_tag_array), 32'(memory_data_valid && k == 7));
      if (memory_data_valid) begin
        chk("widx", 32'(word_index), 32'(k));
        chk("wdata", 32'(data_array_wdata), 32'(memory_data));
        k++;
      end
      if (abort_at > 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_quiet("rst");
        memory_data_valid = 1'b0;
        miss_detected     = 1'b0;
        @(posedge clk); #1;
        chk_quiet("rst_hold");
        rst_n = 1'b1;
        return;
      end
      c++;
      @(posedge clk); #1;
    end
    chk("fill_words", 32'(k), 8);
    chk("fill_cycles", 32'(c), 32'(sched[7] + 1));
    memory_data_valid = 1'b0;
    miss_detected     = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2;
    chk_quiet("por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2, 1'b0);

    run_fill(16'h1236, 0, 1'b0, 0);          // nominal 4-cycle memory
    idle(1, 1'b0);
    run_fill(16'h1236, 0, 1'b1, 0);          // 0x4000 misses during fill are ignored
    idle(1, 1'b0);
    run_fill(16'h4000, 0, 1'b0, 0);
    idle(4, 1'b1);                           // stale returns while idle
    run_fill(16'h2468, 0, 1'b0, 3);          // reset after 3 words
    idle(2, 1'b1);
    run_fill(16'h0080, 0, 1'b0, 0);
    run_fill(16'h5550, 1, 1'b0, 0);          // irregular latency, back-to-back
    run_fill(16'hFFFE, 2, 1'b1, 0);          // top-of-space block

    for (int f = 0; f < 12; f++) begin
      run_fill(16'($urandom), 2, 1'($urandom_range(0, 1)), 0);
      idle(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
